// File: rtl/btb_rt_upd_q_pkg.sv
// rtl/btb_rt_upd_q_pkg.sv - shared BTB field layout and drain FSM types for the retire update queue
package btb_rt_upd_q_pkg;

    localparam int BTB_IDX_LO = 2;
    localparam int BTB_IDX_HI = 9;
    localparam int BTB_PC_W   = 64;

    typedef struct packed {
        logic [BTB_PC_W-1:0] pc;
        logic                dir;
        logic [BTB_PC_W-1:0] tar;
    } btb_upd_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_BLOCKED = 2'd2
    } drain_state_t;

endpackage

// File: rtl/btb_upd_fifo.sv
// rtl/btb_upd_fifo.sv - update queue storage with pointers, occupancy and a newest-entry rewrite port
module btb_upd_fifo
    import btb_rt_upd_q_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  btb_upd_t              push_data,
    input  logic                  pop,
    input  logic                  rewrite,
    input  logic                  rewrite_dir,
    input  logic [BTB_PC_W-1:0]   rewrite_tar,
    output btb_upd_t              head,
    output logic [BTB_PC_W-1:0]   tail_pc,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    btb_upd_t       mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  last_ptr;

    assign last_ptr = wr_ptr - AW'(1);
    assign head     = mem[rd_ptr];
    assign tail_pc  = mem[last_ptr].pc;

    // Pointers wrap naturally at DEPTH; the extra count bit separates full from empty.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end else if (rewrite) begin
            mem[last_ptr].dir <= rewrite_dir;
            mem[last_ptr].tar <= rewrite_tar;
        end
    end

endmodule

// File: rtl/btb_rt_upd_q.sv
// rtl/btb_rt_upd_q.sv - retire-side BTB update queue: coalescing, set-conflict stall and in-order drain
module btb_rt_upd_q
    import btb_rt_upd_q_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int STALL_MAX = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   rt_valid_i,
    input  logic [BTB_PC_W-1:0]    rt_brpc_i,
    input  logic                   rt_brdir_i,
    input  logic [BTB_PC_W-1:0]    rt_brtar_i,
    output logic                   rt_ready_o,
    input  logic                   sp_we_i,
    input  logic [BTB_PC_W-1:0]    sp_brpc_i,
    output logic                   sp_block_o,
    output logic                   btb_rt_we_o,
    output logic [BTB_PC_W-1:0]    btb_rt_brpc_o,
    output logic                   btb_rt_brdir_o,
    output logic [BTB_PC_W-1:0]    btb_rt_brtar_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(STALL_MAX + 1);
    localparam logic [SW-1:0] STALL_LAST = SW'(STALL_MAX - 1);

    drain_state_t         state, state_next;
    logic [SW-1:0]        stall_cnt, stall_next;
    logic                 block_next;
    logic                 accept, conflict, empty;
    logic                 deq, coalesce, push;
    logic [CW-1:0]        count_next;
    btb_upd_t             head, push_data;
    logic [BTB_PC_W-1:0]  tail_pc;

    assign accept   = rt_valid_i & rt_ready_o;
    assign empty    = (count_o == '0);
    assign conflict = sp_we_i & (sp_brpc_i[BTB_IDX_HI:BTB_IDX_LO] == head.pc[BTB_IDX_HI:BTB_IDX_LO]);
    assign push_data = '{pc: rt_brpc_i, dir: rt_brdir_i, tar: rt_brtar_i};

    always_comb begin
        state_next = state;
        stall_next = stall_cnt;
        block_next = 1'b0;
        deq        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!empty) state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (empty) begin
                    state_next = ST_IDLE;
                end else if (conflict) begin
                    stall_next = stall_cnt + SW'(1);
                    state_next = ST_BLOCKED;
                end else begin
                    deq = 1'b1;
                end
            end
            ST_BLOCKED: begin
                // On the last stall cycle fetch1 is held off next cycle, so the head can write then.
                if (conflict && stall_cnt != STALL_LAST) begin
                    stall_next = stall_cnt + SW'(1);
                end else begin
                    deq        = 1'b1;
                    block_next = conflict;
                    stall_next = '0;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Never merge into the newest entry while it is leaving as the sole entry.
        coalesce   = accept & !empty & (rt_brpc_i == tail_pc) & !(deq && count_o == CW'(1));
        push       = accept & !coalesce;
        count_next = count_o + CW'(push) - CW'(deq);

        if (deq) state_next = (count_next == '0) ? ST_IDLE : ST_ISSUE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            stall_cnt      <= '0;
            rt_ready_o     <= 1'b1;
            sp_block_o     <= 1'b0;
            btb_rt_we_o    <= 1'b0;
            btb_rt_brpc_o  <= '0;
            btb_rt_brdir_o <= 1'b0;
            btb_rt_brtar_o <= '0;
        end else begin
            state       <= state_next;
            stall_cnt   <= stall_next;
            rt_ready_o  <= (count_next < CW'(DEPTH));
            sp_block_o  <= block_next;
            btb_rt_we_o <= deq;
            if (deq) begin
                btb_rt_brpc_o  <= head.pc;
                btb_rt_brdir_o <= head.dir;
                btb_rt_brtar_o <= head.tar;
            end
        end
    end

    btb_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .push        (push),
        .push_data   (push_data),
        .pop         (deq),
        .rewrite     (coalesce),
        .rewrite_dir (rt_brdir_i),
        .rewrite_tar (rt_brtar_i),
        .head        (head),
        .tail_pc     (tail_pc),
        .count       (count_o)
    );

endmodule

// File: tb/tb_btb_rt_upd_q.sv
// tb/tb_btb_rt_upd_q.sv - directed self-checking bench for the retire BTB update queue
module tb_btb_rt_upd_q;

    logic        clock = 1'b0;
    logic        reset;
    logic        rt_valid_i;
    logic [63:0] rt_brpc_i;
    logic        rt_brdir_i;
    logic [63:0] rt_brtar_i;
    logic        rt_ready_o;
    logic        sp_we_i;
    logic [63:0] sp_brpc_i;
    logic        sp_block_o;
    logic        btb_rt_we_o;
    logic [63:0] btb_rt_brpc_o;
    logic        btb_rt_brdir_o;
    logic [63:0] btb_rt_brtar_o;
    logic [3:0]  count_o;

    int checks = 0;
    int errors = 0;
    int writes_seen;
    bit mon_en = 1'b0;
    logic [63:0] exp_pc[$];
    logic        exp_dir[$];
    logic [63:0] exp_tar[$];

    btb_rt_upd_q #(.DEPTH(8), .STALL_MAX(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .rt_valid_i     (rt_valid_i),
        .rt_brpc_i      (rt_brpc_i),
        .rt_brdir_i     (rt_brdir_i),
        .rt_brtar_i     (rt_brtar_i),
        .rt_ready_o     (rt_ready_o),
        .sp_we_i        (sp_we_i),
        .sp_brpc_i      (sp_brpc_i),
        .sp_block_o     (sp_block_o),
        .btb_rt_we_o    (btb_rt_we_o),
        .btb_rt_brpc_o  (btb_rt_brpc_o),
        .btb_rt_brdir_o (btb_rt_brdir_o),
        .btb_rt_brtar_o (btb_rt_brtar_o),
        .count_o        (count_o)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] pc, input logic dir, input logic [63:0] tar);
        rt_valid_i = v;
        rt_brpc_i  = pc;
        rt_brdir_i = dir;
        rt_brtar_i = tar;
    endtask

    always @(negedge clock) begin
        if (mon_en && btb_rt_we_o) begin
            writes_seen++;
            if (exp_pc.size() == 0) begin
                check("t2_extra_write", 64'd1, 64'd0);
            end else begin
                check("t2_pc",  btb_rt_brpc_o,  exp_pc.pop_front());
                check("t2_dir", btb_rt_brdir_o, exp_dir.pop_front());
                check("t2_tar", btb_rt_brtar_o, exp_tar.pop_front());
            end
        end
    end

    initial begin
        reset = 1'b1;
        sp_we_i = 1'b0;
        sp_brpc_i = '0;
        drive(1'b0, '0, 1'b0, '0);
        #1;
        check("rst_count", count_o, 0);
        check("rst_ready", rt_ready_o, 1);
        check("rst_we", btb_rt_we_o, 0);
        check("rst_block", sp_block_o, 0);
        tick();
        tick();
        reset = 1'b0;

        // 1: single update into an empty queue
        drive(1'b1, 64'h1000, 1'b1, 64'h2000);
        tick();
        drive(1'b0, '0, 1'b0, '0);
        check("t1_count_e0", count_o, 1);
        check("t1_we_e0", btb_rt_we_o, 0);
        tick();
        check("t1_we_e1", btb_rt_we_o, 0);
        tick();
        check("t1_we_e2", btb_rt_we_o, 1);
        check("t1_pc", btb_rt_brpc_o, 64'h1000);
        check("t1_dir", btb_rt_brdir_o, 1);
        check("t1_tar", btb_rt_brtar_o, 64'h2000);
        check("t1_count_e2", count_o, 0);
        tick();
        check("t1_we_off", btb_rt_we_o, 0);

        // 2: nine back-to-back distinct PCs, drain keeps up
        writes_seen = 0;
        mon_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            check("t2_ready", rt_ready_o, 1);
            drive(1'b1, 64'h3000 + 64'(i) * 64'h4, i[0], 64'h8000 + 64'(i) * 64'h10);
            exp_pc.push_back(64'h3000 + 64'(i) * 64'h4);
            exp_dir.push_back(i[0]);
            exp_tar.push_back(64'h8000 + 64'(i) * 64'h10);
            tick();
        end
        drive(1'b0, '0, 1'b0, '0);
        repeat (8) tick();
        mon_en = 1'b0;
        check("t2_writes", 64'(writes_seen), 9);
        check("t2_left", 64'(exp_pc.size()), 0);
        check("t2_count", count_o, 0);

        // 3: same PC three times while the head is stalled by a conflict
        sp_we_i = 1'b1;
        sp_brpc_i = 64'h7040;
        drive(1'b1, 64'h1040, 1'b1, 64'hA000);
        tick();
        drive(1'b1, 64'h1040, 1'b0, 64'hA100);
        tick();
        drive(1'b1, 64'h1040, 1'b1, 64'hA200);
        tick();
        drive(1'b0, '0, 1'b0, '0);
        sp_we_i = 1'b0;
        check("t3_count", count_o, 1);
        check("t3_we_pre", btb_rt_we_o, 0);
        tick();
        check("t3_we", btb_rt_we_o, 1);
        check("t3_pc", btb_rt_brpc_o, 64'h1040);
        check("t3_dir", btb_rt_brdir_o, 1);
        check("t3_tar", btb_rt_brtar_o, 64'hA200);
        check("t3_count_after", count_o, 0);
        tick();
        check("t3_single_write", btb_rt_we_o, 0);

        // 4: persistent conflict forces a block pulse with the write
        sp_we_i = 1'b1;
        sp_brpc_i = 64'h5008;
        drive(1'b1, 64'h1008, 1'b0, 64'hB000);
        tick();
        drive(1'b0, '0, 1'b0, '0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check($sformatf("t4_block_e%0d", i), sp_block_o, 0);
            check($sformatf("t4_we_e%0d", i), btb_rt_we_o, 0);
        end
        tick();
        check("t4_block_pulse", sp_block_o, 1);
        check("t4_we_pulse", btb_rt_we_o, 1);
        check("t4_pc", btb_rt_brpc_o, 64'h1008);
        check("t4_dir", btb_rt_brdir_o, 0);
        check("t4_tar", btb_rt_brtar_o, 64'hB000);
        sp_we_i = 1'b0;
        tick();
        check("t4_block_end", sp_block_o, 0);
        check("t4_we_end", btb_rt_we_o, 0);
        check("t4_count", count_o, 0);

        // 5: two conflict cycles then the conflict clears
        sp_we_i = 1'b1;
        sp_brpc_i = 64'h3010;
        drive(1'b1, 64'h1010, 1'b1, 64'hC000);
        tick();
        drive(1'b0, '0, 1'b0, '0);
        tick();
        tick();
        tick();
        sp_we_i = 1'b0;
        check("t5_we_stalled", btb_rt_we_o, 0);
        tick();
        check("t5_we", btb_rt_we_o, 1);
        check("t5_pc", btb_rt_brpc_o, 64'h1010);
        check("t5_tar", btb_rt_brtar_o, 64'hC000);
        check("t5_no_block", sp_block_o, 0);
        tick();

        // 6: reset with five queued entries while the head is stalled
        sp_we_i = 1'b1;
        sp_brpc_i = 64'h5008;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 64'h2008 + 64'(i) * 64'h400, 1'b1, 64'hD000 + 64'(i));
            tick();
        end
        drive(1'b0, '0, 1'b0, '0);
        check("t6_count_pre", count_o, 5);
        reset = 1'b1;
        sp_we_i = 1'b0;
        #1;
        check("t6_count", count_o, 0);
        check("t6_ready", rt_ready_o, 1);
        check("t6_we", btb_rt_we_o, 0);
        check("t6_block", sp_block_o, 0);
        check("t6_pc", btb_rt_brpc_o, 0);
        check("t6_tar", btb_rt_brtar_o, 0);
        tick();
        reset = 1'b0;
        writes_seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (btb_rt_we_o) writes_seen++;
        end
        check("t6_no_write", 64'(writes_seen), 0);
        check("t6_count_post", count_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
